gpia_port: RTL and testbench

- Parametrised general-purpose I/O port: WIDTH output bits plus WIDTH input bits.
- Output and interrupt-enable registers support single-cycle load, set, clear and toggle of an arbitrary bit mask.
- Inputs pass through a synchronizer and feed per-bit edge detection, pending latches and one combined interrupt line.
- Sits on the processor's peripheral bus as the next-generation GPIA port, replacing fixed 8-bit output-only octets.

---
 rtl/gpia_port.sv | 130 +++++++++++++
 tb/tb_gpia_port.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/gpia_port.sv
// General-purpose I/O port: mask-writable output and interrupt-enable registers, synchronized inputs with sticky edge flags.
// Define GPIA_PORT_BOTH_EDGES_EN to let falling input edges set pending flags as well as rising ones.
module gpia_port #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             res_i,
    input  logic             stb_i,
    input  logic [1:0]       sel_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic [WIDTH-1:0] pin_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] ien_o,
    output logic [WIDTH-1:0] in_o,
    output logic [WIDTH-1:0] pend_o,
    output logic             irq_o,
    output logic             ack_o
);

    localparam int ARM_CYCLES = SYNC_STAGES + 1;
    localparam int ARM_W      = $clog2(ARM_CYCLES + 1);

    typedef enum logic [1:0] {
        SEL_OUT = 2'b00,
        SEL_IEN = 2'b01,
        SEL_ACK = 2'b10,
        SEL_RSV = 2'b11
    } sel_e;

    typedef enum logic [1:0] {
        MODE_LOAD   = 2'b00,
        MODE_SET    = 2'b01,
        MODE_CLEAR  = 2'b10,
        MODE_TOGGLE = 2'b11
    } mode_e;

    logic [WIDTH-1:0] q_q,    q_d;
    logic [WIDTH-1:0] ien_q,  ien_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
    logic             ack_q;

    logic [WIDTH-1:0] in_w;
    logic [WIDTH-1:0] edge_w;
    logic             armed_w;

    function automatic logic [WIDTH-1:0] apply_mode(
        input logic [1:0]       mode,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] mask
    );
        case (mode_e'(mode))
            MODE_LOAD:   return mask;
            MODE_SET:    return cur | mask;
            MODE_CLEAR:  return cur & ~mask;
            MODE_TOGGLE: return cur ^ mask;
            default:     return cur;
        endcase
    endfunction

    assign in_w    = sync_q[SYNC_STAGES-1];
    assign armed_w = (arm_cnt_q == ARM_W'(ARM_CYCLES));

`ifdef GPIA_PORT_BOTH_EDGES_EN
    assign edge_w = in_w ^ prev_q;
`else
    assign edge_w = in_w & ~prev_q;
`endif

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
        q_d       = q_q;
        ien_d     = ien_q;
        pend_d    = pend_q;
        arm_cnt_d = armed_w ? arm_cnt_q : arm_cnt_q + ARM_W'(1);

        if (stb_i) begin
            case (sel_e'(sel_i))
                SEL_OUT: q_d    = apply_mode(mode_i, q_q, d_i);
                SEL_IEN: ien_d  = apply_mode(mode_i, ien_q, d_i);
                SEL_ACK: pend_d = pend_q & ~d_i;
                default: ;
            endcase
        end

        // A new edge is applied after the acknowledge so a coincident edge keeps its flag.
        if (armed_w) begin
            pend_d = pend_d | edge_w;
        end
    end

    always_ff @(posedge clk_i) begin
        if (res_i) begin
            q_q       <= '0;
            ien_q     <= '0;
            pend_q    <= '0;
            prev_q    <= '0;
            arm_cnt_q <= '0;
            ack_q     <= 1'b0;
            // NOTE: the synchronizer array is reset too, so in_o reads 0 (not stale pins) during reset.
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let every stage sample its predecessor's old value.
            q_q       <= q_d;
            ien_q     <= ien_d;
            pend_q    <= pend_d;
            prev_q    <= in_w;
            arm_cnt_q <= arm_cnt_d;
            ack_q     <= stb_i;
            sync_q[0] <= pin_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign q_o    = q_q;
    assign ien_o  = ien_q;
    assign in_o   = in_w;
    assign pend_o = pend_q;
    assign irq_o  = |(pend_q & ien_q);
    assign ack_o  = ack_q;

endmodule

// File: tb/tb_gpia_port.sv
// Scoreboard bench for gpia_port: each write queues its expected register image, a monitor checks it on ack_o.
module tb_gpia_port;

    localparam int W = 16;

`ifdef GPIA_PORT_BOTH_EDGES_EN
    localparam bit BOTH = 1'b1;
`else
    localparam bit BOTH = 1'b0;
`endif

    logic         clk_i = 1'b0;
    logic         res_i;
    logic         stb_i;
    logic [1:0]   sel_i;
    logic [1:0]   mode_i;
    logic [W-1:0] d_i;
    logic [W-1:0] pin_i;
    logic [W-1:0] q_o;
    logic [W-1:0] ien_o;
    logic [W-1:0] in_o;
    logic [W-1:0] pend_o;
    logic         irq_o;
    logic         ack_o;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] ien;
        logic [W-1:0] pend;
        logic         irq;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    gpia_port #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk_i  (clk_i),
        .res_i  (res_i),
        .stb_i  (stb_i),
        .sel_i  (sel_i),
        .mode_i (mode_i),
        .d_i    (d_i),
        .pin_i  (pin_i),
        .q_o    (q_o),
        .ien_o  (ien_o),
        .in_o   (in_o),
        .pend_o (pend_o),
        .irq_o  (irq_o),
        .ack_o  (ack_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [1:0] sel, input logic [1:0] mode, input logic [W-1:0] d,
                      input logic [W-1:0] eq, input logic [W-1:0] eien, input logic [W-1:0] epend);
        exp_t e;
        e.q    = eq;
        e.ien  = eien;
        e.pend = epend;
        e.irq  = |(epend & eien);
        sb_q.push_back(e);
        stb_i  = 1'b1;
        sel_i  = sel;
        mode_i = mode;
        d_i    = d;
        @(posedge clk_i); #1;
        stb_i  = 1'b0;
        sel_i  = 2'b00;
        mode_i = 2'b00;
        d_i    = '0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Monitor: every acknowledge must match the oldest outstanding write.
    always @(negedge clk_i) begin
        if (ack_o) begin
            if (sb_q.size() == 0) begin
                check("spurious_ack", 32'(ack_o), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_q",    32'(q_o),    32'(e.q));
                check("sb_ien",  32'(ien_o),  32'(e.ien));
                check("sb_pend", 32'(pend_o), 32'(e.pend));
                check("sb_irq",  32'(irq_o),  32'(e.irq));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res_i  = 1'b1;
        stb_i  = 1'b0;
        sel_i  = 2'b00;
        mode_i = 2'b00;
        d_i    = '0;
        pin_i  = 16'hFFFF;

        tick(2);
        check("rst_q",    32'(q_o),    32'h0);
        check("rst_ien",  32'(ien_o),  32'h0);
        check("rst_ack",  32'(ack_o),  32'h0);
        check("rst_in",   32'(in_o),   32'h0);
        check("rst_pend", 32'(pend_o), 32'h0);
        check("rst_irq",  32'(irq_o),  32'h0);
        res_i = 1'b0;

        tick(2);
        check("arm_in",   32'(in_o),   32'hFFFF);
        tick(4);
        check("arm_pend", 32'(pend_o), 32'h0);

        // Dropping every pin: only the both-edges build flags these.
        pin_i = 16'h0000;
        tick(4);
        check("fall_all_pend", 32'(pend_o), BOTH ? 32'hFFFF : 32'h0);
        wr(2'b10, 2'b00, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000);

        // Output register modes, back to back.
        wr(2'b00, 2'b00, 16'h00F0, 16'h00F0, 16'h0000, 16'h0000);
        wr(2'b00, 2'b01, 16'h000F, 16'h00FF, 16'h0000, 16'h0000);
        wr(2'b00, 2'b10, 16'h0030, 16'h00CF, 16'h0000, 16'h0000);
        wr(2'b00, 2'b11, 16'hFFFF, 16'hFF30, 16'h0000, 16'h0000);
        tick(1);
        check("ack_idle", 32'(ack_o), 32'h0);

        // Reserved target: acknowledged, no effect.
        wr(2'b11, 2'b00, 16'hFFFF, 16'hFF30, 16'h0000, 16'h0000);

        // Rising edge with interrupt enabled.
        wr(2'b01, 2'b00, 16'h0004, 16'hFF30, 16'h0004, 16'h0000);
        pin_i = 16'h0004;
        tick(1);
        check("rise_in_early", 32'(in_o), 32'h0000);
        tick(1);
        check("rise_in",   32'(in_o),   32'h0004);
        check("rise_pend0", 32'(pend_o), 32'h0000);
        tick(1);
        check("rise_pend", 32'(pend_o), 32'h0004);
        check("rise_irq",  32'(irq_o),  32'h1);
        wr(2'b10, 2'b11, 16'h0004, 16'hFF30, 16'h0004, 16'h0000);

        // Masked edge: flag latches, irq waits for the enable.
        wr(2'b01, 2'b00, 16'h0000, 16'hFF30, 16'h0000, 16'h0000);
        pin_i = 16'h0024;
        tick(3);
        check("mask_pend", 32'(pend_o), 32'h0020);
        check("mask_irq",  32'(irq_o),  32'h0);
        wr(2'b01, 2'b01, 16'h0020, 16'hFF30, 16'h0020, 16'h0020);

        // Edge on bit 7 reaches pend in the same cycle as its acknowledge.
        pin_i = 16'h00A4;
        tick(2);
        wr(2'b10, 2'b00, 16'h0080, 16'hFF30, 16'h0020, 16'h00A0);
        wr(2'b10, 2'b00, 16'h0080, 16'hFF30, 16'h0020, 16'h0020);

        // Falling pin 2.
        pin_i = 16'h00A0;
        tick(4);
        check("fall2_pend", 32'(pend_o), BOTH ? 32'h0024 : 32'h0020);
        wr(2'b10, 2'b00, 16'hFFFF, 16'hFF30, 16'h0020, 16'h0000);

        // Reset collides with a load strobe and a rising edge on bit 9.
        pin_i = 16'h02A0;
        tick(2);
        res_i  = 1'b1;
        stb_i  = 1'b1;
        sel_i  = 2'b00;
        mode_i = 2'b00;
        d_i    = 16'hAAAA;
        tick(1);
        res_i = 1'b0;
        stb_i = 1'b0;
        d_i   = '0;
        check("mid_q",    32'(q_o),    32'h0);
        check("mid_ien",  32'(ien_o),  32'h0);
        check("mid_pend", 32'(pend_o), 32'h0);
        check("mid_ack",  32'(ack_o),  32'h0);
        check("mid_irq",  32'(irq_o),  32'h0);
        check("mid_in",   32'(in_o),   32'h0);
        tick(6);
        check("rearm_in",   32'(in_o),   32'h02A0);
        check("rearm_pend", 32'(pend_o), 32'h0);

        wr(2'b00, 2'b00, 16'h1234, 16'h1234, 16'h0000, 16'h0000);
        tick(2);
        check("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
